// File: rtl/freq_gate_counter.sv
// Gated frequency counter: counts synchronized rising edges of sig_in over a
// fixed window of GATE_CYCLES clocks, single-shot or continuous.
module freq_gate_counter #(
  parameter int unsigned GATE_CYCLES = 60000000,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont,
  output logic             busy,
  output logic [CNT_W-1:0] result,
  output logic             result_valid,
  output logic             overflow
);

  localparam int unsigned    TMR_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, GATE, DONE} state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sync_prev;
  logic                   w_edge;
  logic [TMR_W-1:0]       r_tmr;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_sat;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   w_sat_nxt;
  logic                   w_last;
  logic                   w_enter;
  logic [CNT_W-1:0]       r_result;
  logic                   r_overflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync      <= '0;
      r_sync_prev <= 1'b0;
    end else begin
      r_sync      <= {r_sync[SYNC_STAGES-2:0], sig_in};
      r_sync_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_edge  = r_sync[SYNC_STAGES-1] & ~r_sync_prev;
  assign w_last  = (r_state == GATE) && (r_tmr == TMR_LAST);
  assign w_enter = (w_next == GATE) && (r_state != GATE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start || cont) w_next = GATE;
      GATE:    if (w_last) w_next = DONE;
      DONE:    w_next = cont ? GATE : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Saturating count including any edge seen in the current cycle.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_sat_nxt = r_sat;
    if (w_edge) begin
      if (r_cnt == '1) w_sat_nxt = 1'b1;
      else             w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmr <= '0;
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (w_enter) begin
      r_tmr <= '0;
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (r_state == GATE) begin
      if (!w_last) r_tmr <= r_tmr + TMR_W'(1);
      r_cnt <= w_cnt_nxt;
      r_sat <= w_sat_nxt;
    end
  end

  // Loaded on the final gate edge so the value is already presented during DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result   <= '0;
      r_overflow <= 1'b0;
    end else if (w_last) begin
      r_result   <= w_cnt_nxt;
      r_overflow <= w_sat_nxt;
    end
  end

  always_comb begin
    busy         = (r_state == GATE);
    result_valid = (r_state == DONE);
    result       = r_result;
    overflow     = r_overflow;
  end

endmodule

// File: tb/tb_freq_gate_counter.sv
// Scoreboard bench for freq_gate_counter: planned sig_in waveforms are turned
// into expected gate results by counting rises inside each gate window.
module tb_freq_gate_counter;

  localparam int GC   = 100;
  localparam int CW   = 5;
  localparam int SS   = 2;
  localparam int MAXC = (1 << CW) - 1;
  localparam int NMAX = 16384;

  typedef struct {
    int cnt;
    bit ovf;
    int at;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          sig_in;
  logic          start;
  logic          cont;
  logic          busy;
  logic [CW-1:0] result;
  logic          result_valid;
  logic          overflow;

  bit   plan  [NMAX];
  bit   bplan [NMAX];
  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   rst_nxt;
  int   last_res = 0;
  bit   last_ovf = 1'b0;

  freq_gate_counter #(
    .GATE_CYCLES(GC),
    .CNT_W      (CW),
    .SYNC_STAGES(SS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sig_in      (sig_in),
    .start       (start),
    .cont        (cont),
    .busy        (busy),
    .result      (result),
    .result_valid(result_valid),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // mode 0: square wave of period par; mode 1: random toggles with par% chance; mode 2: held low
  task automatic fill_plan(input int from, input int len, input int mode, input int par);
    bit v;
    v = plan[from-1];
    for (int i = 0; i < len; i++) begin
      case (mode)
        0:       v = ((i % par) < (par / 2));
        1:       if (int'($urandom_range(0, 99)) < par) v = ~v;
        default: v = 1'b0;
      endcase
      plan[from+i] = v;
    end
  endtask

  // A gate entered at posedge sg counts rises of the synchronized input seen at posedges sg+1..sg+GC.
  task automatic expect_gate(input int sg);
    int   n;
    exp_t e;
    n = 0;
    for (int p = sg + 1; p <= sg + GC; p++)
      if (plan[p-SS] && !plan[p-SS-1]) n++;
    e.cnt = (n > MAXC) ? MAXC : n;
    e.ovf = (n > MAXC);
    e.at  = sg + GC;
    q.push_back(e);
    for (int p = sg; p < sg + GC; p++) bplan[p] = 1'b1;
  endtask

  task automatic drive(input bit st, input bit ct);
    sig_in = plan[cyc+1];
    start  = st;
    cont   = ct;
    rst    = rst_nxt;
    @(negedge clk);
  endtask

  task automatic run(input int n, input bit by_cont, input int mode, input int par, input int extra_at);
    int s;
    int len;
    len = n * (GC + 1);
    fill_plan(cyc + 1, len, mode, par);
    for (int p = cyc + 1 + len; p < cyc + len + 12; p++) plan[p] = 1'b0;
    s = cyc + 1;
    for (int g = 0; g < n; g++) expect_gate(s + g * (GC + 1));
    for (int i = 0; i < len + 6; i++)
      drive((!by_cont && i == 0) || (i == extra_at), by_cont && (i < (n - 1) * (GC + 1) + 50));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        chk("rst_busy", busy, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_overflow", overflow, 0);
        last_res = 0;
        last_ovf = 1'b0;
      end else begin
        chk("busy", busy, bplan[cyc]);
        if (q.size() > 0 && cyc > q[0].at) begin
          checks++;
          failures++;
          $display("FAIL valid_missing: no result_valid at cycle %0d, required one", q[0].at);
          void'(q.pop_front());
        end
        if (result_valid) begin
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_valid at cycle %0d: actual=1 expected=0", cyc);
          end else begin
            e = q.pop_front();
            chk("valid_cycle", cyc, e.at);
            chk("result", result, e.cnt);
            chk("overflow", overflow, e.ovf);
            last_res = e.cnt;
            last_ovf = e.ovf;
          end
        end else begin
          chk("result_hold", result, last_res);
          chk("overflow_hold", overflow, last_ovf);
        end
      end
    end
  end

  initial begin : stimulus
    int s;
    rst     = 1'b1;
    rst_nxt = 1'b1;
    sig_in  = 1'b0;
    start   = 1'b0;
    cont    = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0);
    rst_nxt = 1'b0;

    run(1, 1'b0, 0, 10, -1);       // start on first edge after reset, period 10
    run(1, 1'b0, 2, 0, -1);        // input held low
    run(1, 1'b0, 0, 2, -1);        // period 2 saturates the 5-bit counter
    run(3, 1'b1, 0, 4, -1);        // continuous, three gates, cont dropped mid third gate
    run(1, 1'b0, 0, 10, 30);       // second start mid gate
    run(1, 1'b0, 1, 40, GC + 1);   // start during DONE

    // reset at gate cycle 50
    fill_plan(cyc + 1, GC + 1, 0, 4);
    s = cyc + 1;
    expect_gate(s);
    for (int i = 0; i < 50; i++) drive(i == 0, 1'b0);
    #2;
    rst     = 1'b1;
    rst_nxt = 1'b1;
    void'(q.pop_back());
    for (int p = cyc + 1; p <= s + GC; p++) bplan[p] = 1'b0;
    for (int p = cyc + 1; p < cyc + 130; p++) plan[p] = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_valid", result_valid, 0);
    chk("abort_result", result, 0);
    chk("abort_overflow", overflow, 0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0);
    rst_nxt = 1'b0;
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0);
    run(1, 1'b0, 0, 4, -1);

    for (int k = 0; k < 12; k++) begin
      bit by_cont;
      int mode;
      int par;
      int extra;
      by_cont = ($urandom_range(0, 2) == 0);
      mode    = int'($urandom_range(0, 1));
      par     = (mode == 0) ? int'($urandom_range(2, 12)) : int'($urandom_range(15, 90));
      extra   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, GC + 1)) : -1;
      run(by_cont ? int'($urandom_range(1, 2)) : 1, by_cont, mode, par, extra);
    end

    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/freq_gate_counter.md
FREQ_GATE_COUNTER -- requirements
Module: freq_gate_counter

Interface
REQ-001 Parameter GATE_CYCLES, default 60000000, gate length in clk cycles (1 s at 60 MHz PLL output).
REQ-002 Parameter CNT_W, default 32, width of edge counter and result.
REQ-003 Parameter SYNC_STAGES, default 2, synchronizer flops on sig_in (minimum 2).
REQ-004 clk  input  1  system clock, PLL output (60 MHz nominal); all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 sig_in  input  1  signal under test, asynchronous to clk.
REQ-007 start  input  1  single-cycle request to begin one gate measurement.
REQ-008 cont  input  1  continuous mode; while high, gates repeat back-to-back.
REQ-009 busy  output  1  high while a gate is open.
REQ-010 result  output  CNT_W  rising-edge count of the last completed gate.
REQ-011 result_valid  output  1  one-cycle pulse when result updates.
REQ-012 overflow  output  1  last completed gate saturated the counter.

Function
REQ-013 sig_in SHALL pass through SYNC_STAGES flops; a rising edge SHALL be detected as sync output 1 with previous sync output 0.
REQ-014 FSM states SHALL be IDLE, GATE, DONE.
REQ-015 IDLE -> GATE on the cycle after start=1 or cont=1 is sampled; gate timer and edge counter SHALL clear on entry.
REQ-016 GATE SHALL last exactly GATE_CYCLES clk cycles; each detected edge in those cycles SHALL increment the edge counter by 1.
REQ-017 GATE -> DONE after the final gate cycle; DONE SHALL last exactly one cycle.
REQ-018 In DONE, result SHALL load the edge count, overflow SHALL load the saturation flag, result_valid SHALL be 1.
REQ-019 Latency: result_valid SHALL assert on the cycle immediately after the last gate cycle.
REQ-020 DONE -> GATE if cont=1 in DONE, with no idle cycle between gates; otherwise DONE -> IDLE.
REQ-021 Edge counter SHALL saturate at 2^CNT_W-1, never wrap; the saturation flag SHALL set and hold for the rest of the gate.
REQ-022 busy SHALL be 1 in GATE only.
REQ-023 start while busy or in DONE SHALL be ignored, with no queued request.
REQ-024 An edge detected in the gate's final cycle SHALL be counted. An edge detected in DONE or IDLE SHALL NOT be counted.
REQ-025 result and overflow SHALL hold their value until the next DONE.
REQ-026 Dropping cont mid-gate SHALL let the current gate complete normally, then return to IDLE.

Reset
REQ-027 While rst=1: FSM IDLE, busy=0, result=0, result_valid=0, overflow=0, counters and synchronizer flops 0.
REQ-028 Reset asserted mid-gate SHALL abort the gate with no result_valid pulse. The block SHALL then wait in IDLE for a new start or cont.
REQ-029 After rst deasserts, the first start SHALL be accepted on the first rising clk edge.

Verification (GATE_CYCLES=100 unless noted)
REQ-030 sig_in period 10 clk, one start pulse -> busy high for 100 cycles, result=10, overflow=0, result_valid high 1 cycle at the 101st cycle after start sampled.
REQ-031 sig_in held 0, start -> result=0, overflow=0, one result_valid pulse.
REQ-032 CNT_W=4, sig_in period 2 clk -> result=15, overflow=1.
REQ-033 cont=1 with sig_in period 4 clk for 3 gates -> three result_valid pulses exactly 101 cycles apart, each result=25.
REQ-034 rst=1 at gate cycle 50 -> all outputs 0 immediately, with no result_valid; a later start -> a normal result.
REQ-035 Second start pulse at gate cycle 30 -> ignored, with a single result_valid and no second gate.
